// File: rtl/nibble_unpacker.sv
// nibble_unpacker: rebuilds operands a and b from BEATS nibble-packed bytes
// {a_slice, b_slice}, MS slices first, and presents them on a valid/ready output.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_sof/in_data beat input;
//        out_valid/out_ready, a_out, b_out word output; err framing-error pulse;
//        max_out, a_gt_b compare results (built only with NIBBLE_UNPACKER_CMP_EN defined).
module nibble_unpacker #(
    parameter int DATA_W = 8,
    parameter int BEAT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sof,
    input  logic [2*BEAT_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   a_out,
    output logic [DATA_W-1:0]   b_out,
    output logic                err,
    output logic [DATA_W-1:0]   max_out,
    output logic                a_gt_b
);

    localparam int BEATS = DATA_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    generate
        if ((DATA_W % BEAT_W) != 0 || BEATS < 1) begin : g_bad_cfg
            $error("nibble_unpacker: DATA_W must be a multiple of BEAT_W");
        end
    endgenerate

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] a_sh;
    logic [DATA_W-1:0] b_sh;

    logic              accept;
    logic              orphan;
    logic              last;
    logic              load;
    logic [CNT_W-1:0]  idx;
    logic [BEAT_W-1:0] a_sl;
    logic [BEAT_W-1:0] b_sl;
    logic [DATA_W-1:0] a_base;
    logic [DATA_W-1:0] b_base;
    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_nxt;

    assign in_ready = (state == COLLECT);
    assign accept   = in_valid && in_ready;
    assign a_sl     = in_data[2*BEAT_W-1:BEAT_W];
    assign b_sl     = in_data[BEAT_W-1:0];

    // A beat without sof at cnt 0 has no word to belong to and is dropped.
    assign orphan = !in_sof && (cnt == '0);

    // An sof beat always restarts the word, discarding any partial slices.
    assign idx    = in_sof ? '0 : cnt;
    assign last   = (idx == LAST);
    assign a_base = in_sof ? '0 : a_sh;
    assign b_base = in_sof ? '0 : b_sh;
    assign a_nxt  = (a_base << BEAT_W) | DATA_W'(a_sl);
    assign b_nxt  = (b_base << BEAT_W) | DATA_W'(b_sl);
    assign load   = accept && !orphan && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            a_out     <= '0;
            b_out     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        if (orphan) begin
                            err <= 1'b1;
                        end else begin
                            err  <= in_sof && (cnt != '0);
                            a_sh <= a_nxt;
                            b_sh <= b_nxt;
                            if (last) begin
                                cnt       <= '0;
                                a_out     <= a_nxt;
                                b_out     <= b_nxt;
                                out_valid <= 1'b1;
                                state     <= HOLD;
                            end else begin
                                cnt <= idx + CNT_W'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef NIBBLE_UNPACKER_CMP_EN
    logic gt_nxt;

    assign gt_nxt = (a_nxt > b_nxt);

    // Compare results are captured with the word so they stay aligned with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_gt_b  <= 1'b0;
            max_out <= '0;
        end else if (load) begin
            a_gt_b  <= gt_nxt;
            max_out <= gt_nxt ? a_nxt : b_nxt;
        end
    end
`else
    logic unused_load;

    assign unused_load = load;
    assign a_gt_b      = 1'b0;
    assign max_out     = '0;
`endif

endmodule

// File: tb/tb_nibble_unpacker.sv
// tb_nibble_unpacker: table-driven vectors plus directed sequences for
// backpressure, resync, orphan beats, reset and streaming; scoreboard checks outputs.
module tb_nibble_unpacker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic       err;
    logic [7:0] max_out;
    logic       a_gt_b;

    nibble_unpacker #(.DATA_W(8), .BEAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .err(err),
        .max_out(max_out), .a_gt_b(a_gt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } word_t;

    word_t sb[$];
    int    outs_at[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    err_seen = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        word_t      w;
        logic       egt;
        logic [7:0] emax;
        if (rst_n) begin
            if (err) err_seen++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got a=%h b=%h expected none",
                             a_out, b_out);
                end else begin
                    w = sb.pop_front();
`ifdef NIBBLE_UNPACKER_CMP_EN
                    egt  = (w.a > w.b);
                    emax = egt ? w.a : w.b;
`else
                    egt  = 1'b0;
                    emax = 8'h00;
`endif
                    chk("a_out", a_out, w.a);
                    chk("b_out", b_out, w.b);
                    chk("a_gt_b", a_gt_b, egt);
                    chk("max_out", max_out, emax);
                    outs_at.push_back(cyc);
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic s);
        logic rdy;
        in_valid = 1'b1;
        in_sof   = s;
        in_data  = d;
        for (int n = 0; ; n++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            if (n == 50) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: got no handshake expected accept of %h", d);
                break;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'($urandom);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vt[6];
        int   e0;
        vt[0] = '{8'h3F, 8'h30, 8'h33, 8'hF0};
        vt[1] = '{8'hA5, 8'h5A, 8'hA5, 8'h5A};
        vt[2] = '{8'hFF, 8'h00, 8'hF0, 8'hF0};
        vt[3] = '{8'h11, 8'h22, 8'h12, 8'h12};
        vt[4] = '{8'h12, 8'h34, 8'h13, 8'h24};
        vt[5] = '{8'hC4, 8'h7E, 8'hC7, 8'h4E};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_err", err, 0);
        chk("rst_max_out", max_out, 0);
        chk("rst_a_gt_b", a_gt_b, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e0 = err_seen;
            sb.push_back('{vt[i].ea, vt[i].eb});
            send_beat(vt[i].b0, 1'b1);
            send_beat(vt[i].b1, 1'b0);
            chk("latency_valid", out_valid, 1);
            @(posedge clk);
            #1;
            chk("valid_clear", out_valid, 0);
            chk("no_err", err_seen - e0, 0);
        end

        out_ready = 1'b0;
        sb.push_back('{8'hA5, 8'h5A});
        send_beat(8'hA5, 1'b1);
        send_beat(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_a", a_out, 8'hA5);
            chk("bp_b", b_out, 8'h5A);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);

        e0 = err_seen;
        sb.push_back('{8'h35, 8'h46});
        send_beat(8'h12, 1'b1);
        send_beat(8'h34, 1'b1);
        @(negedge clk);
        chk("resync_err_pulse", err, 1);
        send_beat(8'h56, 1'b0);
        @(posedge clk);
        #1;
        chk("resync_err_count", err_seen - e0, 1);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e0 = err_seen;
        send_beat(8'h77, 1'b0);
        @(negedge clk);
        chk("orphan_err_pulse", err, 1);
        chk("orphan_no_valid", out_valid, 0);
        sb.push_back('{8'hF0, 8'hF0});
        send_beat(8'hFF, 1'b1);
        send_beat(8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk("orphan_err_count", err_seen - e0, 1);

        out_ready = 1'b0;
        send_beat(8'hC4, 1'b1);
        send_beat(8'h7E, 1'b0);
        #2;
        chk("hold_a_before_rst", a_out, 8'hC7);
        rst_n = 1'b0;
        #1;
        chk("hold_rst_valid", out_valid, 0);
        chk("hold_rst_a", a_out, 0);
        chk("hold_rst_b", b_out, 0);
        chk("hold_rst_max", max_out, 0);
        chk("hold_rst_gt", a_gt_b, 0);
        chk("hold_rst_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        e0 = err_seen;
        send_beat(8'h9C, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_a", a_out, 0);
        chk("mid_rst_err", err, 0);
        rst_n = 1'b1;
        sb.push_back('{8'h12, 8'h12});
        send_beat(8'h11, 1'b1);
        send_beat(8'h22, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_rst_no_err", err_seen - e0, 0);

        outs_at.delete();
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{vt[i].ea, vt[i].eb});
            send_beat(vt[i].b0, 1'b1);
            send_beat(vt[i].b1, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("stream_words", outs_at.size(), 4);
        for (int i = 1; i < outs_at.size(); i++)
            chk("stream_period", outs_at[i] - outs_at[i-1], 3);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
